// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcode map, FSM state
// encoding, command layout, widths and the divide-by-zero predicate.
package alu_pkg;

  localparam int OPND_W         = 8;   // operand width
  localparam int RES_W          = 16;  // ALU result width
  localparam int OP_W           = 4;   // opcode width
  localparam int CMD_W          = OP_W + 2 * OPND_W;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] OP_MUL  = 4'b0010;
  localparam logic [OP_W-1:0] OP_DIV  = 4'b0011;
  localparam logic [OP_W-1:0] OP_MOD  = 4'b0100;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0101;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0110;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0111;
  localparam logic [OP_W-1:0] OP_NOT  = 4'b1000;
  localparam logic [OP_W-1:0] OP_NAND = 4'b1001;
  localparam logic [OP_W-1:0] OP_NOR  = 4'b1010;
  localparam logic [OP_W-1:0] OP_XNOR = 4'b1011;
  localparam logic [OP_W-1:0] OP_SHL  = 4'b1100;
  localparam logic [OP_W-1:0] OP_SHR  = 4'b1101;
  localparam logic [OP_W-1:0] OP_ROTL = 4'b1110;
  localparam logic [OP_W-1:0] OP_ROTR = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } cmd_t;

  // DIV/MOD with a zero divisor never trusts the ALU output.
  function automatic logic is_div_by_zero(input cmd_t c);
    return ((c.op == OP_DIV) || (c.op == OP_MOD)) && (c.b == '0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the issuer. Power-of-two depth, pointers wrap naturally,
// head entry is read combinationally.
// Ports: clk, rst_n (sync, active-low), push/wdata, pop/rdata,
//        full, empty, count (0..DEPTH).
module alu_cmd_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, presents each one to an external combinational ALU
// for a single DRIVE cycle and holds the captured result until consumed.
// Ports: clk, rst_n (sync, active-low); cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b
//        upstream; alu_op/alu_a/alu_b to ALU, alu_out/alu_flag_c/alu_flag_z
//        from ALU; res_valid/res_ready/res_data/res_flag_c/res_flag_z/res_op/
//        res_err downstream; busy status.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [OPND_W-1:0] cmd_a,
  input  logic [OPND_W-1:0] cmd_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  input  logic [RES_W-1:0]  alu_out,
  input  logic              alu_flag_c,
  input  logic              alu_flag_z,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              res_flag_c,
  output logic              res_flag_z,
  output logic [OP_W-1:0]   res_op,
  output logic              res_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t           state;
  cmd_t             in_cmd;
  cmd_t             head;
  logic [CMD_W-1:0] head_bits;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             driving;

  assign in_cmd    = '{op: cmd_op, a: cmd_a, b: cmd_b};
  assign head      = cmd_t'(head_bits);
  assign driving   = (state == ST_DRIVE);

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign cmd_ready = rst_n && !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = driving;
  assign busy      = (count != '0) || (state != ST_IDLE);

  assign alu_op    = driving ? head.op : '0;
  assign alu_a     = driving ? head.a  : '0;
  assign alu_b     = driving ? head.b  : '0;

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_cmd),
    .pop   (pop),
    .rdata (head_bits),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // ---- DRIVE -> result register boundary ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_flag_c <= 1'b0;
      res_flag_z <= 1'b0;
      res_op     <= '0;
      res_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) state <= ST_DRIVE;
        end
        ST_DRIVE: begin
          res_op    <= head.op;
          res_valid <= 1'b1;
          if (is_div_by_zero(head)) begin
            res_data   <= '0;
            res_flag_c <= 1'b0;
            res_flag_z <= 1'b1;
            res_err    <= 1'b1;
          end else begin
            res_data   <= alu_out;
            res_flag_c <= alu_flag_c;
            res_flag_z <= alu_flag_z;
            res_err    <= 1'b0;
          end
          state <= ST_RESULT;
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            // No pop happens in RESULT, so the post-edge FIFO is non-empty
            // iff it already was or a command lands at this edge.
            state <= (!empty || push) ? ST_DRIVE : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic [3:0]  alu_op;
  logic [7:0]  alu_a, alu_b;
  logic [15:0] alu_out;
  logic        alu_flag_c, alu_flag_z;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        res_flag_c, res_flag_z;
  logic [3:0]  res_op;
  logic        res_err;
  logic        busy;

  int tests = 0;
  int fails = 0;
  bit rand_ready = 1'b0;

  typedef struct {
    logic [15:0] d;
    logic        c;
    logic        z;
    logic [3:0]  op;
    logic        e;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_issuer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_flag_c(alu_flag_c), .alu_flag_z(alu_flag_z),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flag_c(res_flag_c), .res_flag_z(res_flag_z),
    .res_op(res_op), .res_err(res_err), .busy(busy)
  );

  // Reference combinational ALU attached to the issuer.
  logic [8:0]  s9;
  logic [15:0] r16;
  always_comb begin
    alu_out    = '0;
    alu_flag_c = 1'b0;
    s9         = '0;
    r16        = '0;
    case (alu_op)
      OP_ADD:  begin s9 = {1'b0, alu_a} + {1'b0, alu_b}; alu_out = {7'b0, s9}; alu_flag_c = s9[8]; end
      OP_SUB:  begin s9 = {1'b0, alu_a} - {1'b0, alu_b}; alu_out = {8'b0, s9[7:0]}; alu_flag_c = s9[8]; end
      OP_MUL:  alu_out = {8'b0, alu_a} * {8'b0, alu_b};
      OP_DIV:  alu_out = (alu_b == 0) ? 16'hFFFF : {8'b0, alu_a / alu_b};
      OP_MOD:  alu_out = (alu_b == 0) ? 16'hFFFF : {8'b0, alu_a % alu_b};
      OP_AND:  alu_out = {8'b0, alu_a & alu_b};
      OP_OR:   alu_out = {8'b0, alu_a | alu_b};
      OP_XOR:  alu_out = {8'b0, alu_a ^ alu_b};
      OP_NOT:  alu_out = {8'b0, ~alu_a};
      OP_NAND: alu_out = {8'b0, ~(alu_a & alu_b)};
      OP_NOR:  alu_out = {8'b0, ~(alu_a | alu_b)};
      OP_XNOR: alu_out = {8'b0, ~(alu_a ^ alu_b)};
      OP_SHL:  alu_out = {8'b0, alu_a} << alu_b[2:0];
      OP_SHR:  alu_out = {8'b0, alu_a} >> alu_b[2:0];
      OP_ROTL: begin r16 = {alu_a, alu_a} << alu_b[2:0]; alu_out = {8'b0, r16[15:8]}; end
      default: begin r16 = {alu_a, alu_a} >> alu_b[2:0]; alu_out = {8'b0, r16[7:0]}; end
    endcase
  end
  assign alu_flag_z = (alu_out == 16'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input logic [15:0] d, input logic c, input logic z,
                            input logic [3:0] op, input logic e);
    exp_t x;
    x.d = d; x.c = c; x.z = z; x.op = op; x.e = e;
    exp_q.push_back(x);
  endtask

  // Offer one command and wait (bounded) until it is accepted.
  task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bit done;
    done = 1'b0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      #1;
      done = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    check("push_accept", 32'(done), 32'd1);
  endtask

  // Consume n results, comparing each against the expectation queue in order.
  // A command left pending on cmd_valid is retired when it is accepted.
  task automatic drain(input int n);
    int   got;
    bit   push_now;
    exp_t x;
    got = 0;
    for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
      res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (res_valid && res_ready) begin
        if (exp_q.size() > 0) begin
          x = exp_q.pop_front();
          check("res_data", 32'(res_data), 32'(x.d));
          check("res_flag_c", 32'(res_flag_c), 32'(x.c));
          check("res_flag_z", 32'(res_flag_z), 32'(x.z));
          check("res_op", 32'(res_op), 32'(x.op));
          check("res_err", 32'(res_err), 32'(x.e));
        end else begin
          check("unexpected_result", 32'(res_valid), 32'd0);
        end
        got++;
      end
      push_now = cmd_valid && cmd_ready;
      tick();
      if (push_now) cmd_valid = 1'b0;
    end
    check("drain_count", 32'(got), 32'(n));
  endtask

  logic [3:0] bop [6];
  logic [7:0] ba  [6];
  logic [7:0] bb  [6];
  logic [15:0] wrap_exp [16];
  int n_acc;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single SUB(30,10): DRIVE one cycle after accept, result one cycle later
    res_ready = 1'b1;
    cmd_op = OP_SUB; cmd_a = 8'd30; cmd_b = 8'd10; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("single_n_valid", 32'(res_valid), 32'd0);
    check("single_n_busy", 32'(busy), 32'd1);
    check("single_idle_alu_op", 32'(alu_op), 32'd0);
    tick();
    check("single_drive_op", 32'(alu_op), 32'(OP_SUB));
    check("single_drive_a", 32'(alu_a), 32'd30);
    check("single_drive_b", 32'(alu_b), 32'd10);
    check("single_drive_valid", 32'(res_valid), 32'd0);
    tick();
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_data", 32'(res_data), 32'd20);
    check("single_op", 32'(res_op), 32'd1);
    check("single_err", 32'(res_err), 32'd0);
    check("single_result_alu_op", 32'(alu_op), 32'd0);
    tick();
    check("single_consumed", 32'(res_valid), 32'd0);
    check("single_idle_busy", 32'(busy), 32'd0);

    // Burst under backpressure: 1 in result register + 4 in FIFO, 6th stalls
    res_ready = 1'b0;
    bop[0] = OP_ADD; ba[0] = 8'd30;  bb[0] = 8'd10;
    bop[1] = OP_MUL; ba[1] = 8'd30;  bb[1] = 8'd10;
    bop[2] = OP_DIV; ba[2] = 8'd100; bb[2] = 8'd20;
    bop[3] = OP_AND; ba[3] = 8'd100; bb[3] = 8'd20;
    bop[4] = OP_XOR; ba[4] = 8'd100; bb[4] = 8'd20;
    bop[5] = OP_OR;  ba[5] = 8'd100; bb[5] = 8'd20;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_op = bop[i]; cmd_a = ba[i]; cmd_b = bb[i]; cmd_valid = 1'b1;
      #1;
      if (!cmd_ready) break;
      n_acc++;
      tick();
    end
    check("burst_accepted", 32'(n_acc), 32'd5);
    for (int i = 0; i < 3; i++) begin
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      check("stall_res_valid", 32'(res_valid), 32'd1);
      check("stall_res_data", 32'(res_data), 32'd40);
      tick();
    end
    // Full FIFO while the result is consumed: no pass-through acceptance
    res_ready = 1'b1;
    #1;
    check("fullpop_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    check("fullpop_drive_ready", 32'(cmd_ready), 32'd0);
    check("fullpop_drive_op", 32'(alu_op), 32'(OP_MUL));
    expect_res(16'd300, 1'b0, 1'b0, OP_MUL, 1'b0);
    expect_res(16'd5,   1'b0, 1'b0, OP_DIV, 1'b0);
    expect_res(16'd4,   1'b0, 1'b0, OP_AND, 1'b0);
    expect_res(16'd112, 1'b0, 1'b0, OP_XOR, 1'b0);
    expect_res(16'd116, 1'b0, 1'b0, OP_OR,  1'b0);
    drain(5);
    check("burst_idle_busy", 32'(busy), 32'd0);

    // Divide-by-zero guard, then a normal divide and flag cases
    res_ready = 1'b0;
    push(OP_DIV, 8'd100, 8'd0);
    push(OP_MOD, 8'd100, 8'd0);
    push(OP_DIV, 8'd100, 8'd20);
    push(OP_ADD, 8'd200, 8'd100);
    push(OP_SUB, 8'd10,  8'd10);
    expect_res(16'd0,   1'b0, 1'b1, OP_DIV, 1'b1);
    expect_res(16'd0,   1'b0, 1'b1, OP_MOD, 1'b1);
    expect_res(16'd5,   1'b0, 1'b0, OP_DIV, 1'b0);
    expect_res(16'd300, 1'b1, 1'b0, OP_ADD, 1'b0);
    expect_res(16'd0,   1'b0, 1'b1, OP_SUB, 1'b0);
    drain(5);

    // Wrap: all 16 opcodes with A=100, B=20, random res_ready
    wrap_exp = '{16'd120, 16'd80, 16'd2000, 16'd5, 16'd0, 16'd4, 16'd116, 16'd112,
                 16'd155, 16'd251, 16'd139, 16'd143, 16'd1600, 16'd6, 16'd70, 16'd70};
    rand_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      res_ready = 1'b0;
      for (int j = 0; j < 4; j++) begin
        push(4'(g * 4 + j), 8'd100, 8'd20);
        expect_res(wrap_exp[g * 4 + j], 1'b0, (wrap_exp[g * 4 + j] == 16'd0),
                   4'(g * 4 + j), 1'b0);
      end
      drain(4);
    end
    rand_ready = 1'b0;
    res_ready = 1'b1;
    tick();
    check("wrap_count", 32'(dut.u_fifo.count), 32'd0);
    check("wrap_busy", 32'(busy), 32'd0);
    check("wrap_cmd_ready", 32'(cmd_ready), 32'd1);

    // Reset in RESULT with 3 entries queued
    res_ready = 1'b0;
    push(OP_ADD, 8'd1, 8'd2);
    push(OP_SUB, 8'd5, 8'd3);
    push(OP_MUL, 8'd2, 8'd3);
    push(OP_AND, 8'd7, 8'd3);
    check("prerst_res_valid", 32'(res_valid), 32'd1);
    check("prerst_count", 32'(dut.u_fifo.count), 32'd3);
    rst_n = 1'b0;
    tick();
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("midrst_res_data", 32'(res_data), 32'd0);
    rst_n = 1'b1;
    res_ready = 1'b1;
    #1;
    check("release_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_stale_valid", 32'(res_valid), 32'd0);
      check("no_stale_busy", 32'(busy), 32'd0);
    end
    push(OP_ADD, 8'd1, 8'd2);
    expect_res(16'd3, 1'b0, 1'b0, OP_ADD, 1'b0);
    drain(1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
